// File: rtl/seq_bucket_shift.sv
// Sequential shifter: accepts one request over valid/ready, shifts one bit per clock,
// and returns the result over a second valid/ready handshake.
module seq_bucket_shift #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] din_i,
   input  logic [SHW-1:0]   shamt_i,
   input  logic             l_r_i,
   input  logic             a_l_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] work_q, work_d;
   logic [SHW-1:0]   cnt_q;
   logic             lr_q, al_q, sign_q;
   logic             in_ready_q, out_valid_q, busy_q;

   // Fill bit uses the MSB latched at accept, not the current work MSB.
   always_comb begin
      work_d = work_q;
      if (lr_q) begin
         work_d = {work_q[WIDTH-2:0], 1'b0};
      end else begin
         work_d = {al_q & sign_q, work_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         work_q      <= '0;
         cnt_q       <= '0;
         lr_q        <= 1'b0;
         al_q        <= 1'b0;
         sign_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  work_q     <= din_i;
                  cnt_q      <= shamt_i;
                  lr_q       <= l_r_i;
                  al_q       <= a_l_i;
                  sign_q     <= din_i[WIDTH-1];
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (shamt_i == '0) begin
                     state_q     <= StDone;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= StShift;
                  end
               end
            end
            StShift: begin
               work_q <= work_d;
               cnt_q  <= cnt_q - SHW'(1);
               if (cnt_q == SHW'(1)) begin
                  state_q     <= StDone;
                  out_valid_q <= 1'b1;
               end
            end
            StDone: begin
               if (out_ready_i) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= StIdle;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;
   assign dout_o      = work_q;

endmodule

// File: tb/tb_seq_bucket_shift.sv
// Bench for seq_bucket_shift: vector table plus scoreboard, with backpressure and
// mid-shift reset sequences.
module tb_seq_bucket_shift;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] din;
   logic [2:0] shamt;
   logic       l_r;
   logic       a_l;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] dout;
   logic       busy;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] sb_q[$];
   int         lat_q[$];

   typedef struct {
      logic [7:0] din;
      logic [2:0] sh;
      logic       lr;
      logic       al;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[11];

   seq_bucket_shift #(.WIDTH(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .din_i       (din),
      .shamt_i     (shamt),
      .l_r_i       (l_r),
      .a_l_i       (a_l),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .dout_o      (dout),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic start_req(input logic [7:0] d, input logic [2:0] s, input logic lr,
                            input logic al, input logic [7:0] exp);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      din      = d;
      shamt    = s;
      l_r      = lr;
      a_l      = al;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", in_ready, 1);
      @(posedge clk);
      sb_q.push_back(exp);
      lat_q.push_back(int'(s) + 1);
      #1;
      // Request inputs are free to change once accepted.
      in_valid = 1'b0;
      din      = 8'($urandom);
      shamt    = 3'($urandom);
      l_r      = 1'($urandom);
      a_l      = 1'($urandom);
   endtask

   task automatic wait_result();
      int         lat = 0;
      logic [7:0] e;
      int         el;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 40);
      chk("out_valid_seen", out_valid, 1);
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
         e  = sb_q.pop_front();
         el = lat_q.pop_front();
         chk("latency", lat, el);
         chk("dout", dout, e);
         chk("busy_done", busy, 1);
         chk("in_ready_done", in_ready, 0);
      end
   endtask

   initial begin
      int seen;
      tbl[0]  = '{8'hD5, 3'd1, 1'b0, 1'b0, 8'h6A};
      tbl[1]  = '{8'hD5, 3'd2, 1'b0, 1'b1, 8'hF5};
      tbl[2]  = '{8'hD5, 3'd3, 1'b1, 1'b1, 8'hA8};
      tbl[3]  = '{8'hD5, 3'd0, 1'b0, 1'b1, 8'hD5};
      tbl[4]  = '{8'hD5, 3'd7, 1'b0, 1'b1, 8'hFF};
      tbl[5]  = '{8'hD5, 3'd7, 1'b0, 1'b0, 8'h01};
      tbl[6]  = '{8'hD5, 3'd7, 1'b1, 1'b0, 8'h80};
      tbl[7]  = '{8'h35, 3'd4, 1'b0, 1'b1, 8'h03};
      tbl[8]  = '{8'h80, 3'd3, 1'b0, 1'b1, 8'hF0};
      tbl[9]  = '{8'h81, 3'd1, 1'b1, 1'b0, 8'h02};
      tbl[10] = '{8'h3C, 3'd0, 1'b1, 1'b1, 8'h3C};

      rst       = 1'b1;
      in_valid  = 1'b0;
      din       = 8'h00;
      shamt     = 3'd0;
      l_r       = 1'b0;
      a_l       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         start_req(tbl[i].din, tbl[i].sh, tbl[i].lr, tbl[i].al, tbl[i].exp);
         wait_result();
         @(negedge clk);
         chk("post_hs_out_valid", out_valid, 0);
         chk("post_hs_in_ready", in_ready, 1);
      end

      // Backpressure: result held, stray requests ignored.
      out_ready = 1'b0;
      start_req(8'hD5, 3'd2, 1'b0, 1'b1, 8'hF5);
      wait_result();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_dout", dout, 8'hF5);
         chk("bp_in_ready", in_ready, 0);
         in_valid = (i % 2 == 0);
         din      = 8'h00;
         shamt    = 3'd0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_out_valid", out_valid, 0);
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_busy", busy, 0);

      // Reset during SHIFT drops the in-flight request.
      start_req(8'hD5, 3'd3, 1'b1, 1'b1, 8'hA8);
      @(negedge clk);
      chk("mid_shift_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_dout", dout, 0);
      chk("mrst_in_ready", in_ready, 1);
      chk("mrst_busy", busy, 0);
      if (sb_q.size() != 0) begin
         void'(sb_q.pop_back());
         void'(lat_q.pop_back());
      end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("no_stale_result", seen, 0);
      start_req(8'hD5, 3'd1, 1'b0, 1'b0, 8'h6A);
      wait_result();
      @(negedge clk);
      chk("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
